// File: rtl/onehot_pkg.sv
// Shared types for the 16-to-4 one-hot encoder: code and word types, buffer entry.
// Multi-hot detection feeds the ONEHOT_STRICT_EN build of the encoder core.
package onehot_pkg;

  localparam int N = 4;
  localparam int W = 1 << N;

  typedef logic signed [N-1:0] code_t;
  typedef logic [W-1:0]        onehot_t;

  typedef struct packed {
    code_t code;
    logic  err;
  } enc_t;

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic multi_hot(input onehot_t d);
    return (d & (d - onehot_t'(1))) != onehot_t'(0);
  endfunction

endpackage

// File: rtl/onehot_enc16_if.sv
// Handshake bus of onehot_enc16: word input side, result output side, error counter.
interface onehot_enc16_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [(1<<N)-1:0]     D;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [N-1:0]   S;
  logic                  err;
  logic [CNT_W-1:0]      err_cnt;

  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, S, err, err_cnt
  );

  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, S, err, err_cnt
  );

endinterface

// File: rtl/onehot_enc_core.sv
// Combinational one-hot to signed code encoder; the highest set bit wins.
// ONEHOT_STRICT_EN makes multi-hot words erroneous as well as the all-zero word.
module onehot_enc_core
  import onehot_pkg::*;
(
  input  onehot_t i_d,
  output enc_t    o_enc
);

  code_t w_code;
  logic  w_err;

  // Priority encode from bit 0 upward so the highest set bit overwrites lower ones.
  always_comb begin
    w_code = code_t'(0);
    for (int i = 0; i < W; i++) begin
      w_code = i_d[i] ? code_t'(i) : w_code;
    end
`ifdef ONEHOT_STRICT_EN
    w_err = (i_d == onehot_t'(0)) || multi_hot(i_d);
`else
    w_err = (i_d == onehot_t'(0));
`endif
  end

  assign o_enc = '{code: w_code, err: w_err};

endmodule

// File: rtl/onehot_enc16.sv
// Registered 16-to-4 one-hot encoder with a 2-entry result buffer and a saturating
// malformed-word counter. ONEHOT_STRICT_EN selects strict multi-hot error reporting.
module onehot_enc16
  import onehot_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  onehot_enc16_if.slave  bus
);

  if (N != onehot_pkg::N) begin : g_bad_n
    $error("onehot_enc16: N must match onehot_pkg::N");
  end

  enc_t             w_enc;
  logic             w_push;
  logic             w_pop;
  enc_t             w_slot0_nxt;
  enc_t             w_slot1_nxt;
  logic [1:0]       w_count_nxt;
  logic [CNT_W-1:0] w_err_cnt_nxt;

  enc_t             r_slot0;
  enc_t             r_slot1;
  logic [1:0]       r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_err_cnt;

  onehot_enc_core u_core (
    .i_d   (bus.D),
    .o_enc (w_enc)
  );

  assign w_push = bus.in_valid && r_in_ready;
  assign w_pop  = r_out_valid && bus.out_ready;

  // Slot 0 is always the head, so the outputs come straight from a register.
  always_comb begin
    w_slot0_nxt   = r_slot0;
    w_slot1_nxt   = r_slot1;
    w_count_nxt   = r_count;
    w_err_cnt_nxt = r_err_cnt;
    case ({w_push, w_pop})
      2'b10: begin
        if (r_count == 2'd0) begin
          w_slot0_nxt = w_enc;
        end else begin
          w_slot1_nxt = w_enc;
        end
        w_count_nxt = r_count + 2'd1;
      end
      2'b01: begin
        w_slot0_nxt = r_slot1;
        w_count_nxt = r_count - 2'd1;
      end
      // Push implies count<2 and pop implies count>0, so count is 1 here.
      2'b11: begin
        w_slot0_nxt = w_enc;
      end
      default: begin
        w_count_nxt = r_count;
      end
    endcase
    if (w_push && w_enc.err && (r_err_cnt != {CNT_W{1'b1}})) begin
      w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
    end else begin
      w_err_cnt_nxt = r_err_cnt;
    end
  end

  // Buffer, handshake flags and error counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot0     <= '{code: code_t'(0), err: 1'b0};
      r_slot1     <= '{code: code_t'(0), err: 1'b0};
      r_count     <= 2'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_err_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_slot0     <= w_slot0_nxt;
      r_slot1     <= w_slot1_nxt;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt < 2'd2);
      r_out_valid <= (w_count_nxt > 2'd0);
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.S         = r_slot0.code;
  assign bus.err       = r_slot0.err;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_onehot_enc16.sv
// Directed bench for onehot_enc16 with a queue-based reference model and per-cycle compare.
module tb_onehot_enc16;
  import onehot_pkg::*;

  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef ONEHOT_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef struct {
    logic [3:0] s;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  bit   chk_on = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   m_cnt = 0;

  always #5 clk = ~clk;

  onehot_enc16_if #(.N(4), .CNT_W(CW)) bus ();

  onehot_enc16 #(.N(4), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic exp_t ref_enc(input logic [15:0] d);
    exp_t r;
    int   hi = 0;
    int   ones = 0;
    for (int k = 0; k < 16; k++) begin
      if (d[k]) begin
        hi = k;
        ones++;
      end
    end
    r.s = hi[3:0];
    r.e = (ones == 0) || (STRICT && ones > 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic step();
    bit   push;
    bit   pop;
    exp_t e;
    @(posedge clk);
    if (!rst) begin
      push = bus.in_valid && (q.size() < 2);
      pop  = bus.out_ready && (q.size() > 0);
      e    = ref_enc(bus.D);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        if (e.e && m_cnt < CNT_MAX) m_cnt++;
      end
    end
    #2;
  endtask

  // Hand-computed expectation applied to both the DUT and the model head.
  task automatic expect_out(input string name, input logic [3:0] s, input logic e, input int cnt);
    check({name, ".S"}, {28'd0, $unsigned(bus.S)}, {28'd0, s});
    check({name, ".err"}, {31'd0, bus.err}, {31'd0, e});
    check({name, ".cnt"}, {30'd0, bus.err_cnt}, cnt);
    check({name, ".model_s"}, (q.size() > 0) ? {28'd0, q[0].s} : 32'hFFFF_FFFF, {28'd0, s});
    check({name, ".model_e"}, (q.size() > 0) ? {31'd0, q[0].e} : 32'hFFFF_FFFF, {31'd0, e});
  endtask

  task automatic push_word(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.D        = d;
    step();
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      if (rst) begin
        check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.S", {28'd0, $unsigned(bus.S)}, 32'd0);
        check("rst.err", {31'd0, bus.err}, 32'd0);
        check("rst.err_cnt", {30'd0, bus.err_cnt}, 32'd0);
      end else begin
        check("in_ready", {31'd0, bus.in_ready}, (q.size() < 2) ? 32'd1 : 32'd0);
        check("out_valid", {31'd0, bus.out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
        check("err_cnt", {30'd0, bus.err_cnt}, m_cnt);
        if (q.size() > 0) begin
          check("S", {28'd0, $unsigned(bus.S)}, {28'd0, q[0].s});
          check("err", {31'd0, bus.err}, {31'd0, q[0].e});
        end
      end
    end
  end

  logic [15:0] stream [6] = '{16'h0002, 16'h0400, 16'h1000, 16'h0080, 16'h0008, 16'h4000};

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.D         = 16'h0000;
    bus.out_ready = 1'b0;
    #1 chk_on = 1'b1;
    step();
    step();
    check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b0;

    // Basic one-hot words, 1-cycle latency.
    bus.out_ready = 1'b1;
    push_word(16'h0001);
    expect_out("w0001", 4'h0, 1'b0, 0);
    push_word(16'h8000);
    expect_out("w8000", 4'hF, 1'b0, 0);
    bus.in_valid = 1'b0;
    step();

    // All-zero word is an error.
    push_word(16'h0000);
    expect_out("w0000", 4'h0, 1'b1, 1);
    bus.in_valid = 1'b0;
    step();

    // Multi-hot word: highest index wins, error only in strict build.
    push_word(16'h0110);
    expect_out("w0110", 4'h8, STRICT, STRICT ? 2 : 1);
    bus.in_valid = 1'b0;
    step();

    // Stalled consumer fills the buffer and holds off a third word.
    bus.out_ready = 1'b0;
    push_word(16'h0004);
    push_word(16'h0020);
    check("full.in_ready", {31'd0, bus.in_ready}, 32'd0);
    expect_out("full.head", 4'h2, 1'b0, STRICT ? 2 : 1);
    push_word(16'h0040);
    push_word(16'h0040);
    check("held.in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    expect_out("drain1", 4'h5, 1'b0, STRICT ? 2 : 1);
    check("drain1.in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    check("drain2.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Streaming with count held at 1.
    push_word(16'h0001);
    foreach (stream[i]) begin
      push_word(stream[i]);
      check("stream.out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    expect_out("stream.last", 4'hE, 1'b0, STRICT ? 2 : 1);
    bus.in_valid = 1'b0;
    step();

    // Saturating counter, then reset mid-stream.
    for (int i = 0; i < 4; i++) push_word(16'h0000);
    check("sat.err_cnt", {30'd0, bus.err_cnt}, 32'd3);
    bus.out_ready = 1'b0;
    push_word(16'h0000);
    rst = 1'b1;
    q.delete();
    m_cnt = 0;
    #1;
    check("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst.err_cnt", {30'd0, bus.err_cnt}, 32'd0);
    check("midrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    push_word(16'h0200);
    expect_out("post_rst", 4'h9, 1'b0, 0);
    bus.in_valid = 1'b0;
    step();
    step();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
